// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a req/ack
// memory handshake, and hands each instruction with its PC to the control unit.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] num_fetched,
  output logic        misalign_err
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        flush, flush_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic        valid_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] inst_pc_nxt;
  logic [31:0] count_nxt;
  logic        err_nxt;

  logic redir_ok;
  logic redir_bad;
  logic handshake;

  assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
  assign handshake = (state == ST_HOLD) && inst_valid && inst_ready;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    flush_nxt   = flush;
    req_nxt     = imem_req;
    addr_nxt    = imem_addr;
    valid_nxt   = inst_valid;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    count_nxt   = num_fetched;
    err_nxt     = misalign_err;

    case (state)
      ST_FETCH: begin
        if (redir_bad) begin
          state_nxt = ST_HALT;
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
          valid_nxt = 1'b0;
          flush_nxt = 1'b0;
        end else if (!imem_req) begin
          // First request after reset; a same-cycle redirect simply retargets it.
          req_nxt  = 1'b1;
          addr_nxt = redir_ok ? redirect_pc : pc;
          pc_nxt   = redir_ok ? redirect_pc : pc;
        end else if (imem_ack) begin
          if (redir_ok) begin
            pc_nxt    = redirect_pc;
            addr_nxt  = redirect_pc;
            flush_nxt = 1'b0;
          end else if (flush) begin
            // Stale data from before a redirect: drop it and refetch at the new PC.
            flush_nxt = 1'b0;
            addr_nxt  = pc;
          end else begin
            inst_nxt    = imem_rdata;
            inst_pc_nxt = pc;
            pc_nxt      = pc + 32'd4;
            req_nxt     = 1'b0;
            valid_nxt   = 1'b1;
            state_nxt   = ST_HOLD;
          end
        end else if (redir_ok) begin
          // Outstanding request cannot be aborted; remember to discard its data.
          pc_nxt    = redirect_pc;
          flush_nxt = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redir_bad) begin
          state_nxt = ST_HALT;
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
          valid_nxt = 1'b0;
          flush_nxt = 1'b0;
        end else if (handshake) begin
          valid_nxt = 1'b0;
          count_nxt = num_fetched + 32'd1;
          state_nxt = ST_FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = redir_ok ? redirect_pc : pc;
          pc_nxt    = redir_ok ? redirect_pc : pc;
        end else if (redir_ok) begin
          valid_nxt = 1'b0;
          state_nxt = ST_FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = redirect_pc;
          pc_nxt    = redirect_pc;
        end
      end

      ST_HALT: begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end

      default: begin
        state_nxt = ST_FETCH;
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      inst_valid   <= 1'b0;
      inst         <= NOP_INST;
      inst_pc      <= RESET_PC;
      num_fetched  <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      flush        <= flush_nxt;
      imem_req     <= req_nxt;
      imem_addr    <= addr_nxt;
      inst_valid   <= valid_nxt;
      inst         <= inst_nxt;
      inst_pc      <= inst_pc_nxt;
      num_fetched  <= count_nxt;
      misalign_err <= err_nxt;
    end
  end

endmodule
